// File: rtl/fb_writer_if.sv
// Pixel stream in, frame-buffer write port out, plus status strobes.
// The writer takes the slave side; the pixel source takes the master side.
interface fb_writer_if;
    logic        en;
    logic        s_valid;
    logic [11:0] s_data;
    logic        s_sof;
    logic        s_ready;
    logic        we;
    logic [16:0] waddr;
    logic [11:0] wdata;
    logic        frame_done;
    logic        sof_err;
    logic        busy;

    modport master (
        output en, s_valid, s_data, s_sof,
        input  s_ready, we, waddr, wdata, frame_done, sof_err, busy
    );

    modport slave (
        input  en, s_valid, s_data, s_sof,
        output s_ready, we, waddr, wdata, frame_done, sof_err, busy
    );
endinterface

// File: rtl/fb_writer.sv
// Writes an RGB444 pixel stream into a raster frame buffer.
// The frame is framed by s_sof; one registered write per accepted beat.
module fb_writer #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    fb_writer_if.slave  fb
);
    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [16:0]        ptr_q, ptr_d;
    logic               we_q, we_d;
    logic [16:0]        waddr_q, waddr_d;
    logic [11:0]        wdata_q, wdata_d;
    logic               frame_done_q, frame_done_d;
    logic               sof_err_q, sof_err_d;

    logic               accept;
    logic               do_write;
    logic [COL_W-1:0]   pos_col;
    logic [ROW_W-1:0]   pos_row;
    logic [16:0]        pos_addr;

    // An s_sof beat always lands at pixel (0,0), whatever the counters hold.
    assign accept   = fb.s_valid & fb.en;
    assign do_write = accept & (fb.s_sof | (state_q == WRITE));
    assign pos_col  = fb.s_sof ? '0 : col_q;
    assign pos_row  = fb.s_sof ? '0 : row_q;
    assign pos_addr = fb.s_sof ? '0 : ptr_q;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        ptr_d        = ptr_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;

        if (do_write) begin
            we_d      = 1'b1;
            waddr_d   = pos_addr;
            wdata_d   = fb.s_data;
            sof_err_d = fb.s_sof & (state_q == WRITE);
            state_d   = WRITE;
            ptr_d     = pos_addr + 17'd1;
            if (pos_col == COL_W'(H_RES - 1)) begin
                col_d = '0;
                if (pos_row == ROW_W'(V_RES - 1)) begin
                    // Last pixel: park counters at zero so the next frame starts clean.
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                    row_d        = '0;
                    ptr_d        = '0;
                end else begin
                    row_d = pos_row + ROW_W'(1);
                end
            end else begin
                col_d = pos_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            ptr_q        <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ptr_q        <= ptr_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign fb.s_ready    = fb.en;
    assign fb.we         = we_q;
    assign fb.waddr      = waddr_q;
    assign fb.wdata      = wdata_q;
    assign fb.frame_done = frame_done_q;
    assign fb.sof_err    = sof_err_q;
    assign fb.busy       = (state_q == WRITE);
endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: an address-based frame model queues each
// expected write when a beat is driven and pops it when the DUT writes.
module tb_fb_writer;
    localparam int H_RES = 320;
    localparam int V_RES = 240;
    localparam int FRAME = H_RES * V_RES;

    typedef struct {
        int          addr;
        logic [11:0] data;
        logic        sofErr;
        logic        frameDone;
    } expWrite_t;

    logic clk = 1'b0;
    logic rst_n;
    int   testsRun  = 0;
    int   failCount = 0;
    int   mAddr     = 0;
    logic mState    = 1'b0;
    expWrite_t expQ[$];

    fb_writer_if fb();

    fb_writer #(.H_RES(H_RES), .V_RES(V_RES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fb    (fb.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare what the DUT wrote on the last edge against the oldest expectation.
    task automatic sampleOutputs();
        expWrite_t e;
        checkOutput("busy", 32'(fb.busy), 32'(mState));
        checkOutput("we", 32'(fb.we), 32'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            if (fb.we) begin
                checkOutput("waddr", 32'(fb.waddr), 32'(e.addr));
                checkOutput("wdata", 32'(fb.wdata), 32'(e.data));
                checkOutput("sof_err", 32'(fb.sof_err), 32'(e.sofErr));
                checkOutput("frame_done", 32'(fb.frame_done), 32'(e.frameDone));
            end
        end else begin
            checkOutput("frame_done_idle", 32'(fb.frame_done), 32'd0);
            checkOutput("sof_err_idle", 32'(fb.sof_err), 32'd0);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic sof, input logic [11:0] d, input logic e);
        expWrite_t x;
        @(negedge clk);
        sampleOutputs();
        fb.s_valid = v;
        fb.s_sof   = sof;
        fb.s_data  = d;
        fb.en      = e;
        #1;
        checkOutput("s_ready", 32'(fb.s_ready), 32'(e));
        if (v && e && (sof || mState)) begin
            x.addr      = sof ? 0 : mAddr;
            x.data      = d;
            x.sofErr    = sof & mState;
            x.frameDone = (x.addr == FRAME - 1);
            expQ.push_back(x);
            mAddr  = x.addr + 1;
            mState = !x.frameDone;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_we"}, 32'(fb.we), 32'd0);
        checkOutput({tag, "_waddr"}, 32'(fb.waddr), 32'd0);
        checkOutput({tag, "_wdata"}, 32'(fb.wdata), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(fb.frame_done), 32'd0);
        checkOutput({tag, "_sof_err"}, 32'(fb.sof_err), 32'd0);
        checkOutput({tag, "_busy"}, 32'(fb.busy), 32'd0);
    endtask

    // Pull rst_n low between edges; registered outputs must clear at once.
    task automatic midCycleReset();
        @(negedge clk);
        sampleOutputs();
        fb.s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        expQ.delete();
        mState = 1'b0;
        mAddr  = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [11:0] rndPix();
        return 12'($urandom_range(0, 4095));
    endfunction

    initial begin
        rst_n      = 1'b0;
        fb.en      = 1'b0;
        fb.s_valid = 1'b0;
        fb.s_sof   = 1'b0;
        fb.s_data  = 12'h000;
        #3;
        checkResetOutputs("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Beats before any s_sof are discarded, then the frame opens with 12'hABC.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, rndPix(), 1'b1);
        applyStimulus(1'b1, 1'b1, 12'hABC, 1'b1);

        // Full frame, with a 10-cycle stall just before pixel 500.
        for (int i = 1; i < FRAME; i++) begin
            if (i == 500) begin
                for (int s = 0; s < 10; s++) applyStimulus(1'b1, 1'b0, rndPix(), 1'b0);
            end
            applyStimulus(1'b1, 1'b0, rndPix(), 1'b1);
        end

        // Back-to-back next frame, restarted by an s_sof at beat 1000.
        applyStimulus(1'b1, 1'b1, rndPix(), 1'b1);
        for (int i = 1; i < 1000; i++) applyStimulus(1'b1, 1'b0, rndPix(), 1'b1);
        applyStimulus(1'b1, 1'b1, rndPix(), 1'b1);
        for (int i = 0; i < 999; i++) applyStimulus(1'b1, 1'b0, rndPix(), 1'b1);

        midCycleReset();

        // After reset only an s_sof beat reopens the frame.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, rndPix(), 1'b1);
        applyStimulus(1'b1, 1'b1, 12'h5A5, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, rndPix(), 1'b1);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
